gearbox_2_to_1_fc: RTL

- Consumes one 2*width token per upstream valid-ready transfer and emits it as two width-wide tokens on a valid-ready downstream port.
- Example: "0110" => "01", "10".
- Sits directly downstream of the 1-to-2 gearbox, which packs {first, second}. With msb_first=1, the pair (1-to-2 then 2-to-1) is an identity stream.
- Buffers up to two words so that up_ready is registered and the downstream port sustains one beat per cycle.

---
 rtl/gearbox_2_to_1_fc_pkg.sv | 29 ++
 rtl/gearbox_2_to_1_fc_if.sv | 33 +++
 rtl/gearbox_2_to_1_fc_skid.sv | 89 ++++++++
 rtl/gearbox_2_to_1_fc.sv | 68 ++++++
 4 files changed

// File: rtl/gearbox_2_to_1_fc_pkg.sv
// Shared types and helpers for the gearbox family (1-to-2 / 2-to-1 width converters).
package gearbox_fc_pkg;

  // Widest half-token any gearbox in this family is built for.
  localparam int MAX_WIDTH = 64;

  // Which half of a packed word is presented next.
  typedef enum logic {
    HALF_FIRST  = 1'b0,
    HALF_SECOND = 1'b1
  } half_t;

  // Returns the word shifted so the requested half sits in bits [half_width-1:0].
  // Callers zero-extend their word into the MAX_WIDTH container and keep the low bits.
  function automatic logic [2*MAX_WIDTH-1:0] select_half(
    input logic [2*MAX_WIDTH-1:0] word,
    input int                     half_width,
    input half_t                  half,
    input logic                   msb_first
  );
    logic take_upper;
    take_upper = msb_first ^ (half == HALF_SECOND);
    if (take_upper) begin
      return word >> half_width;
    end
    return word;
  endfunction

endpackage

// File: rtl/gearbox_2_to_1_fc_if.sv
// Upstream word port and downstream half-token port of the 2-to-1 gearbox.
interface gearbox_2_to_1_fc_if #(
  parameter int width = 8
) ();

  logic               up_valid;
  logic               up_ready;
  logic [2*width-1:0] up_data;
  logic               down_valid;
  logic [width-1:0]   down_data;
  logic               down_ready;

  // Gearbox side.
  modport slave (
    input  up_valid,
    input  up_data,
    input  down_ready,
    output up_ready,
    output down_valid,
    output down_data
  );

  // Producer/consumer side (upstream source and downstream sink together).
  modport master (
    output up_valid,
    output up_data,
    output down_ready,
    input  up_ready,
    input  down_valid,
    input  down_data
  );

endinterface

// File: rtl/gearbox_2_to_1_fc_skid.sv
// Two-entry word buffer (main + skid) with a flop-driven in_ready.
// The head word lives in main; skid only fills when main is busy and not retiring.
module skid_buffer_fc #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data
);

  logic [data_width-1:0] main_q;
  logic [data_width-1:0] skid_q;
  logic                  main_full_q;
  logic                  main_full_d;
  logic                  skid_full_q;
  logic                  skid_full_d;
  logic                  ready_q;
  logic                  in_hs;
  logic                  out_hs;
  logic                  load_main_in;
  logic                  load_main_skid;
  logic                  load_skid;

  assign in_hs  = in_valid & ready_q;
  assign out_hs = main_full_q & out_ready;

  // Decide where an accepted word lands and how the occupancy flags move.
  // in_hs never coincides with skid_full_q because in_ready is low then.
  always_comb begin
    main_full_d    = main_full_q;
    skid_full_d    = skid_full_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (out_hs) begin
      if (skid_full_q) begin
        load_main_skid = 1'b1;
        skid_full_d    = 1'b0;
      end else if (in_hs) begin
        load_main_in = 1'b1;
      end else begin
        main_full_d = 1'b0;
      end
    end else if (in_hs) begin
      if (!main_full_q) begin
        load_main_in = 1'b1;
        main_full_d  = 1'b1;
      end else begin
        load_skid   = 1'b1;
        skid_full_d = 1'b1;
      end
    end
  end

  // Occupancy flags and the registered ready, which anticipates next cycle's skid state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_full_q <= 1'b0;
      skid_full_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      main_full_q <= main_full_d;
      skid_full_q <= skid_full_d;
      ready_q     <= ~skid_full_d;
    end
  end

  // Data registers carry no reset; the flags qualify them.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_full_q;
  assign out_data  = main_q;

endmodule

// File: rtl/gearbox_2_to_1_fc.sv
// 2-to-1 gearbox: splits each upstream 2*width word into two width-wide beats.
// A word is retired from the buffer only when its second half is taken downstream.
module gearbox_2_to_1_fc
  import gearbox_fc_pkg::*;
#(
  parameter int width     = 8,
  parameter bit msb_first = 1'b1
) (
  input logic                clk,
  input logic                rst,
  gearbox_2_to_1_fc_if.slave bus
);

  logic                   word_valid;
  logic                   word_ready;
  logic [2*width-1:0]     word_data;
  logic [2*MAX_WIDTH-1:0] word_ext;
  logic [2*MAX_WIDTH-1:0] sel_wide;
  logic                   unused_sel;
  logic                   down_hs;
  half_t                  phase_q;
  half_t                  phase_d;

  skid_buffer_fc #(
    .data_width (2*width)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.up_valid),
    .in_ready  (bus.up_ready),
    .in_data   (bus.up_data),
    .out_valid (word_valid),
    .out_ready (word_ready),
    .out_data  (word_data)
  );

  assign down_hs = word_valid & bus.down_ready;

  // Phase register; a reset mid-word discards any half already emitted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= HALF_FIRST;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Each downstream handshake advances to the other half.
  always_comb begin
    phase_d = phase_q;
    if (down_hs) begin
      phase_d = (phase_q == HALF_FIRST) ? HALF_SECOND : HALF_FIRST;
    end
  end

  // Half mux and retire request; down_ready reaches only the buffer's data path, never up_ready.
  always_comb begin
    word_ext                = '0;
    word_ext[2*width-1:0]   = word_data;
    sel_wide                = select_half(word_ext, width, phase_q, msb_first);
    word_ready              = bus.down_ready & (phase_q == HALF_SECOND);
    bus.down_valid          = word_valid;
    bus.down_data           = sel_wide[width-1:0];
  end

  assign unused_sel = ^sel_wide;

endmodule
